// File: rtl/dram_uart_pkg.sv
// dram_uart_pkg: shared streamer state encoding and dRam control codes.
package dram_uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    FINISH
  } state_t;
  localparam logic [1:0] MEM_IDLE     = 2'b00;
  localparam logic [1:0] MEM_READ     = 2'b01;
  localparam logic [1:0] MEM_WRITE_OP = 2'b10;
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 bit timer and shifter; tx is registered one cycle behind the bit phase.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       bit_end,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    shift;
  logic          active;
  assign bit_end = active && cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_done = bit_end && idx == 4'd9;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      active <= 1'b0;
      tx     <= 1'b1;
    end else begin
      tx <= !active ? 1'b1 : idx == 4'd0 ? 1'b0 : idx == 4'd9 ? 1'b1 : shift[0];
      if (load) begin
        active <= 1'b1;
        shift  <= data;
        cnt    <= '0;
        idx    <= '0;
      end else if (active) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
        if (bit_end) begin
          idx <= idx + 4'd1;
          if (idx >= 4'd1 && idx <= 4'd8) shift <= shift >> 1;
          if (idx == 4'd9) active <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/dram_uart_streamer.sv
// dram_uart_streamer: reads a dRam region byte by byte and streams it out as 8N1 UART.
module dram_uart_streamer
  import dram_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] byte_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_ctrl,
  input  logic [7:0]        mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, remaining;
  logic [2:0]        bit_cnt;
  logic              load, bit_end, tx_done;
  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .data(mem_rdata),
    .tx(tx),
    .bit_end(bit_end),
    .tx_done(tx_done)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      bit_cnt   <= '0;
    end else begin
      if (state == IDLE && start && byte_count != '0) begin
        addr      <= base_addr;
        remaining <= byte_count;
      end
      if (state == STOP_BIT && tx_done) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
      bit_cnt <= state != DATA_BITS ? '0 : bit_cnt + 3'(bit_end);
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = byte_count != '0 ? RD_REQ : FINISH;
      RD_REQ:    state_nxt = RD_WAIT;
      RD_WAIT:   state_nxt = START_BIT;
      START_BIT: if (bit_end) state_nxt = DATA_BITS;
      DATA_BITS: if (bit_end && bit_cnt == 3'd7) state_nxt = STOP_BIT;
      STOP_BIT:  if (tx_done) state_nxt = remaining == ADDR_W'(1) ? FINISH : RD_REQ;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    mem_addr = addr;
    mem_ctrl = state == RD_REQ ? MEM_READ : MEM_IDLE;
    load     = state == RD_WAIT;
    busy     = state != IDLE && state != FINISH;
    done     = state == FINISH;
  end
endmodule

// File: doc/dram_uart_streamer.md
Name: dram_uart_streamer

Overview:
Reads a contiguous region of data memory (dRam) after the processor finishes downsampling and transmits each byte over an 8N1 UART TX line. The block is the memory-reader side of the dRam port, mirroring the processor's write side. It shares the dRam port with the processor through an external mux selected by busy. It gives the host a way to pull the downsampled image off-chip.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
ADDR_W, 19, dRam address width.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  single-cycle request to begin streaming; sampled only in IDLE.
base_addr  input  ADDR_W  first dRam address to send; latched on accepted start.
byte_count  input  ADDR_W  number of bytes to send; latched on accepted start.
mem_addr  output  ADDR_W  dRam address (dAddr).
mem_ctrl  output  2  dRam control (MEM_WRITE bus): 2'b00 idle, 2'b01 read; 2'b10 is never driven.
mem_rdata  input  8  dRam read data (d_out); valid exactly 1 cycle after the read request.
tx  output  1  UART serial output, idle high.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, tx=1, busy=0, done=0, mem_ctrl=2'b00, mem_addr=0, all counters 0. Reset mid-frame aborts immediately; no stop bit is completed.
- States: IDLE, RD_REQ, RD_WAIT, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE: with start=1 and byte_count!=0, latch addr=base_addr and remaining=byte_count, then go to RD_REQ. With start=1 and byte_count=0, go to FINISH; no memory access and no tx activity. With start=0, stay in IDLE.
- RD_REQ (1 cycle): mem_addr=addr, mem_ctrl=2'b01. Next state is RD_WAIT.
- RD_WAIT (1 cycle): mem_ctrl=2'b00. Latch shift_reg=mem_rdata. Next state is START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits, LSB first. Each bit is held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then decrement remaining and increment addr.
  - If remaining becomes 0, go to FINISH.
  - Otherwise go to RD_REQ.
- Address increment wraps modulo 2^ADDR_W (0x7FFFF+1 -> 0x00000).
- FINISH (1 cycle): done=1 and busy=0. Next state is IDLE.
- busy=1 in every state except IDLE and FINISH.
- Per-byte period: 2 + 10*CLKS_PER_BIT cycles. Inter-byte idle gap on tx is 2 cycles at tx=1.
- Latency: start accepted at edge N. RD_REQ is active in cycle N+1. tx falls at edge N+3.
- start asserted while busy is ignored. Changes to base_addr and byte_count after acceptance have no effect.
- tx is registered and glitch-free. mem_ctrl=2'b01 is asserted only in RD_REQ, exactly once per byte.

Decomposition:
- Shared package dram_uart_pkg holds:
  - the state enum;
  - MEM_IDLE=2'b00, MEM_READ=2'b01, MEM_WRITE_OP=2'b10, reusable by the processor and dRam.
- One sub-module, uart_tx_core, handles bit timing and the shift register:
  - inputs: load, data[7:0];
  - outputs: tx, tx_done pulse.
- The top FSM owns the addressing and byte-count logic.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Single byte: dRam[0x00010]=0xA5, start with base=0x10, count=1.
  - Required: one read at 0x10.
  - tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - done pulses exactly at cycle 2+40 after acceptance.
- Burst of 3: mem[0x100..0x102]=0x00,0xFF,0x3C.
  - Required: three reads at ascending addresses.
  - Byte spacing is 42 cycles; the UART monitor decodes 00 FF 3C.
  - busy is high throughout; done fires once.
- Wrap-around: base=0x7FFFF, count=2.
  - Required: reads at 0x7FFFF, then 0x00000.
- Zero count: start with count=0.
  - Required: done pulse 1 cycle after acceptance.
  - tx stays 1, mem_ctrl stays 00, busy never rises.
- Reset mid-frame: rst_n=0 during DATA_BITS of byte 2 of 4.
  - Required: next edge gives tx=1, busy=0, mem_ctrl=00, state IDLE.
  - A new start with count=1 then completes normally.
- Start while busy: pulse start again during byte 1 with different base and count.
  - Required: it is ignored; the original transfer completes unchanged.
